// File: rtl/net_pkg.sv
// Shared switch definitions: packet-demux FSM state encoding and drop-counter width.
`timescale 1ns/1ps
package net_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  localparam int DROP_W = 16;

endpackage

// File: rtl/pktdemux.sv
// One-to-many packet demultiplexer: routes whole packets to the port picked on the first beat.
// Define PKTDEMUX_BROADCAST_EN to let a multi-hot destination replicate a packet to several ports.
`timescale 1ns/1ps
module pktdemux
  import net_pkg::*;
#(
  parameter int unsigned NOUT = 4,
  parameter int unsigned DW   = 64,
  parameter int unsigned BW   = $clog2(DW/8) + 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DW-1:0]     S_DATA,
  input  logic [BW-1:0]     S_BYTES,
  input  logic              S_LAST,
  input  logic              S_ABORT,
  input  logic [NOUT-1:0]   i_dest,
  output logic [NOUT-1:0]   M_VALID,
  input  logic [NOUT-1:0]   M_READY,
  output logic [DW-1:0]     M_DATA,
  output logic [BW-1:0]     M_BYTES,
  output logic              M_LAST,
  output logic [NOUT-1:0]   M_ABORT,
  output logic [DROP_W-1:0] o_drops
);

  localparam logic [BW-1:0]     FULL_BYTES = BW'(DW/8);
  localparam logic [DROP_W-1:0] DROP_ONE   = {{(DROP_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [NOUT-1:0]   route_q, route_d;
  logic [NOUT-1:0]   m_valid_q, m_valid_d;
  logic [NOUT-1:0]   m_abort_q, m_abort_d;
  logic [DW-1:0]     m_data_q, m_data_d;
  logic [BW-1:0]     m_bytes_q, m_bytes_d;
  logic              m_last_q, m_last_d;
  logic [DROP_W-1:0] drops_q, drops_d;

  logic [NOUT-1:0]   mask;
  logic [NOUT-1:0]   load_mask;
  logic              dest_valid;
  logic              can_accept;
  logic              accept;
  logic              beat_ok;

`ifdef PKTDEMUX_BROADCAST_EN
  assign dest_valid = |i_dest;
`else
  assign dest_valid = $onehot(i_dest);
`endif

  // The output beat registers are shared by all ports, so a load must also wait for any
  // still-pending beat (possibly left over from the previous packet) to be taken.
  always_comb begin
    mask = '0;
    unique case (state_q)
      ST_IDLE:  mask = dest_valid ? i_dest : '0;
      ST_ROUTE: mask = route_q;
      default:  mask = '0;
    endcase
    can_accept = (mask == '0) || ((m_valid_q & ~M_READY) == '0);
    S_READY    = (state_q == ST_DROP) || S_ABORT || can_accept;
    accept     = S_VALID && S_READY;
    beat_ok    = accept && !S_ABORT;
  end

  always_comb begin
    state_d   = state_q;
    route_d   = route_q;
    load_mask = '0;
    m_abort_d = '0;
    drops_d   = drops_q;
    unique case (state_q)
      ST_IDLE: begin
        if (beat_ok) begin
          if (dest_valid) begin
            load_mask = i_dest;
            route_d   = i_dest;
            if (!S_LAST) state_d = ST_ROUTE;
          end else begin
            if (drops_q != '1) drops_d = drops_q + DROP_ONE;
            if (!S_LAST) state_d = ST_DROP;
          end
        end
      end
      ST_ROUTE: begin
        if (S_ABORT) begin
          m_abort_d = route_q;
          state_d   = ST_IDLE;
        end else if (beat_ok) begin
          load_mask = route_q;
          if (S_LAST) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (S_ABORT) state_d = ST_IDLE;
        else if (beat_ok && S_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // An abort discards whatever beat the routed ports were still holding.
    m_valid_d = ((m_valid_q & ~M_READY) | load_mask) & ~m_abort_d;
    m_data_d  = m_data_q;
    m_bytes_d = m_bytes_q;
    m_last_d  = m_last_q;
    if (load_mask != '0) begin
      m_data_d  = S_DATA;
      m_bytes_d = (S_BYTES == '0) ? FULL_BYTES : S_BYTES;
      m_last_d  = S_LAST;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      route_q   <= '0;
      m_valid_q <= '0;
      m_abort_q <= '0;
      m_data_q  <= '0;
      m_bytes_q <= '0;
      m_last_q  <= 1'b0;
      drops_q   <= '0;
    end else begin
      state_q   <= state_d;
      route_q   <= route_d;
      m_valid_q <= m_valid_d;
      m_abort_q <= m_abort_d;
      m_data_q  <= m_data_d;
      m_bytes_q <= m_bytes_d;
      m_last_q  <= m_last_d;
      drops_q   <= drops_d;
    end
  end

  assign M_VALID = m_valid_q;
  assign M_ABORT = m_abort_q;
  assign M_DATA  = m_data_q;
  assign M_BYTES = m_bytes_q;
  assign M_LAST  = m_last_q;
  assign o_drops = drops_q;

endmodule

// File: tb/tb_pktdemux.sv
// Directed, table-driven bench for pktdemux (NOUT=4, DW=64); honours PKTDEMUX_BROADCAST_EN.
`timescale 1ns/1ps
module tb_pktdemux;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        S_VALID;
  logic        S_READY;
  logic [63:0] S_DATA;
  logic [3:0]  S_BYTES;
  logic        S_LAST;
  logic        S_ABORT;
  logic [3:0]  i_dest;
  logic [3:0]  M_VALID;
  logic [3:0]  M_READY;
  logic [63:0] M_DATA;
  logic [3:0]  M_BYTES;
  logic        M_LAST;
  logic [3:0]  M_ABORT;
  logic [15:0] o_drops;

  int errors = 0;
  int checks = 0;

  pktdemux dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .S_VALID  (S_VALID),
    .S_READY  (S_READY),
    .S_DATA   (S_DATA),
    .S_BYTES  (S_BYTES),
    .S_LAST   (S_LAST),
    .S_ABORT  (S_ABORT),
    .i_dest   (i_dest),
    .M_VALID  (M_VALID),
    .M_READY  (M_READY),
    .M_DATA   (M_DATA),
    .M_BYTES  (M_BYTES),
    .M_LAST   (M_LAST),
    .M_ABORT  (M_ABORT),
    .o_drops  (o_drops)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        s_valid;
    logic [63:0] data;
    logic [3:0]  bytes;
    logic        last;
    logic        abort;
    logic [3:0]  dest;
    logic [3:0]  m_ready;
    logic        exp_s_ready;
    logic [3:0]  exp_valid;
    logic [3:0]  exp_abort;
    logic        chk_data;
    logic [63:0] exp_data;
    logic [3:0]  exp_bytes;
    logic        exp_last;
    logic [15:0] exp_drops;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic sv, input logic [63:0] d, input logic [3:0] b, input logic l,
    input logic ab, input logic [3:0] de, input logic [3:0] mr,
    input logic esr, input logic [3:0] ev, input logic [3:0] ea,
    input logic chk, input logic [63:0] ed, input logic [3:0] eb, input logic el,
    input logic [15:0] edr);
    vec_t v;
    v.s_valid = sv; v.data = d; v.bytes = b; v.last = l; v.abort = ab;
    v.dest = de; v.m_ready = mr; v.exp_s_ready = esr; v.exp_valid = ev;
    v.exp_abort = ea; v.chk_data = chk; v.exp_data = ed; v.exp_bytes = eb;
    v.exp_last = el; v.exp_drops = edr;
    return v;
  endfunction

  function automatic vec_t idle(input logic [15:0] edr);
    return mk(1'b0, 64'h0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b1111,
              1'b1, 4'b0000, 4'b0000, 1'b0, 64'h0, 4'd0, 1'b0, edr);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sv, input logic [63:0] d, input logic [3:0] b, input logic l,
                       input logic ab, input logic [3:0] de, input logic [3:0] mr);
    S_VALID = sv; S_DATA = d; S_BYTES = b; S_LAST = l; S_ABORT = ab; i_dest = de; M_READY = mr;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    drive(v.s_valid, v.data, v.bytes, v.last, v.abort, v.dest, v.m_ready);
    #1;
    checkOutput($sformatf("v%0d S_READY", idx), {63'b0, S_READY}, {63'b0, v.exp_s_ready});
    @(posedge i_clk);
    #1;
    checkOutput($sformatf("v%0d M_VALID", idx), {60'b0, M_VALID}, {60'b0, v.exp_valid});
    checkOutput($sformatf("v%0d M_ABORT", idx), {60'b0, M_ABORT}, {60'b0, v.exp_abort});
    checkOutput($sformatf("v%0d o_drops", idx), {48'b0, o_drops}, {48'b0, v.exp_drops});
    if (v.chk_data) begin
      checkOutput($sformatf("v%0d M_DATA", idx), M_DATA, v.exp_data);
      checkOutput($sformatf("v%0d M_BYTES", idx), {60'b0, M_BYTES}, {60'b0, v.exp_bytes});
      checkOutput($sformatf("v%0d M_LAST", idx), {63'b0, M_LAST}, {63'b0, v.exp_last});
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " M_VALID"}, {60'b0, M_VALID}, 64'h0);
    checkOutput({tag, " M_ABORT"}, {60'b0, M_ABORT}, 64'h0);
    checkOutput({tag, " M_DATA"}, M_DATA, 64'h0);
    checkOutput({tag, " M_BYTES"}, {60'b0, M_BYTES}, 64'h0);
    checkOutput({tag, " M_LAST"}, {63'b0, M_LAST}, 64'h0);
    checkOutput({tag, " o_drops"}, {48'b0, o_drops}, 64'h0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [15:0] db;
    i_reset_n = 1'b0;
    drive(1'b0, 64'h0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    repeat (2) @(posedge i_clk);
    #1;
    checkAllZero("reset");
    i_reset_n = 1'b1;

    // Single port, 3 beats, all ready; i_dest ignored after the first beat.
    vecs.push_back(mk(1, 64'hA1, 4'd8, 0, 0, 4'b0100, 4'b1111, 1, 4'b0100, 4'b0000, 1, 64'hA1, 4'd8, 0, 16'd0));
    vecs.push_back(mk(1, 64'hA2, 4'd8, 0, 0, 4'b0000, 4'b1111, 1, 4'b0100, 4'b0000, 1, 64'hA2, 4'd8, 0, 16'd0));
    vecs.push_back(mk(1, 64'hA3, 4'd0, 1, 0, 4'b0001, 4'b1111, 1, 4'b0100, 4'b0000, 1, 64'hA3, 4'd8, 1, 16'd0));
    vecs.push_back(idle(16'd0));
    // Port 2 back-pressured for 5 cycles mid-packet.
    vecs.push_back(mk(1, 64'hB1, 4'd8, 0, 0, 4'b0100, 4'b1111, 1, 4'b0100, 4'b0000, 1, 64'hB1, 4'd8, 0, 16'd0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1, 64'hB2, 4'd8, 0, 0, 4'b0100, 4'b1011, 0, 4'b0100, 4'b0000, 1, 64'hB1, 4'd8, 0, 16'd0));
    vecs.push_back(mk(1, 64'hB2, 4'd8, 0, 0, 4'b0100, 4'b1111, 1, 4'b0100, 4'b0000, 1, 64'hB2, 4'd8, 0, 16'd0));
    vecs.push_back(mk(1, 64'hB3, 4'd3, 1, 0, 4'b0100, 4'b1111, 1, 4'b0100, 4'b0000, 1, 64'hB3, 4'd3, 1, 16'd0));
    vecs.push_back(idle(16'd0));
    // Zero destination: 4 beats swallowed, then a normal single-beat packet.
    vecs.push_back(mk(1, 64'hC1, 4'd8, 0, 0, 4'b0000, 4'b1111, 1, 4'b0000, 4'b0000, 0, 64'h0, 4'd0, 0, 16'd1));
    vecs.push_back(mk(1, 64'hC2, 4'd8, 0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 64'h0, 4'd0, 0, 16'd1));
    vecs.push_back(mk(1, 64'hC3, 4'd8, 0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 64'h0, 4'd0, 0, 16'd1));
    vecs.push_back(mk(1, 64'hC4, 4'd8, 1, 0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 64'h0, 4'd0, 0, 16'd1));
    vecs.push_back(mk(1, 64'hD1, 4'd8, 1, 0, 4'b0001, 4'b1111, 1, 4'b0001, 4'b0000, 1, 64'hD1, 4'd8, 1, 16'd1));
    vecs.push_back(idle(16'd1));
    // Abort on beat 2 of a packet to port 1, then the next first beat re-samples i_dest.
    vecs.push_back(mk(1, 64'hE1, 4'd8, 0, 0, 4'b0010, 4'b0000, 1, 4'b0010, 4'b0000, 1, 64'hE1, 4'd8, 0, 16'd1));
    vecs.push_back(mk(1, 64'hE2, 4'd8, 0, 1, 4'b0010, 4'b0000, 1, 4'b0000, 4'b0010, 1, 64'hE1, 4'd8, 0, 16'd1));
    vecs.push_back(idle(16'd1));
    vecs.push_back(mk(1, 64'hF1, 4'd8, 1, 0, 4'b1000, 4'b1111, 1, 4'b1000, 4'b0000, 1, 64'hF1, 4'd8, 1, 16'd1));
    vecs.push_back(idle(16'd1));
    // Multi-hot destination 4'b0011.
`ifdef PKTDEMUX_BROADCAST_EN
    db = 16'd1;
    vecs.push_back(mk(1, 64'h61, 4'd8, 0, 0, 4'b0011, 4'b1111, 1, 4'b0011, 4'b0000, 1, 64'h61, 4'd8, 0, db));
    vecs.push_back(mk(1, 64'h62, 4'd8, 0, 0, 4'b0011, 4'b1101, 0, 4'b0010, 4'b0000, 1, 64'h61, 4'd8, 0, db));
    vecs.push_back(mk(1, 64'h62, 4'd8, 1, 0, 4'b0011, 4'b1111, 1, 4'b0011, 4'b0000, 1, 64'h62, 4'd8, 1, db));
    vecs.push_back(idle(db));
`else
    db = 16'd2;
    vecs.push_back(mk(1, 64'h61, 4'd8, 0, 0, 4'b0011, 4'b1111, 1, 4'b0000, 4'b0000, 0, 64'h0, 4'd0, 0, db));
    vecs.push_back(mk(1, 64'h62, 4'd8, 0, 0, 4'b0011, 4'b1101, 1, 4'b0000, 4'b0000, 0, 64'h0, 4'd0, 0, db));
    vecs.push_back(mk(1, 64'h62, 4'd8, 1, 0, 4'b0011, 4'b1111, 1, 4'b0000, 4'b0000, 0, 64'h0, 4'd0, 0, db));
    vecs.push_back(idle(db));
`endif
    // A beat under S_ABORT in IDLE is discarded and does not open a packet.
    vecs.push_back(mk(1, 64'h71, 4'd8, 0, 1, 4'b0001, 4'b1111, 1, 4'b0000, 4'b0000, 0, 64'h0, 4'd0, 0, db));
    vecs.push_back(mk(1, 64'h72, 4'd5, 1, 0, 4'b0100, 4'b1111, 1, 4'b0100, 4'b0000, 1, 64'h72, 4'd5, 1, db));
    vecs.push_back(idle(db));

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Reset asserted mid-packet clears everything; the next beat is a first beat.
    drive(1'b1, 64'h81, 4'd8, 1'b0, 1'b0, 4'b0010, 4'b0000);
    @(posedge i_clk);
    #1;
    checkOutput("midpkt M_VALID", {60'b0, M_VALID}, 64'h2);
    i_reset_n = 1'b0;
    drive(1'b0, 64'h0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    #1;
    checkAllZero("midreset");
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    drive(1'b1, 64'h91, 4'd8, 1'b1, 1'b0, 4'b0100, 4'b1111);
    #1;
    checkOutput("postreset S_READY", {63'b0, S_READY}, 64'h1);
    @(posedge i_clk);
    #1;
    checkOutput("postreset M_VALID", {60'b0, M_VALID}, 64'h4);
    checkOutput("postreset M_DATA", M_DATA, 64'h91);
    drive(1'b0, 64'h0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b1111);
    @(posedge i_clk);
    #1;

    // Drive o_drops to saturation with back-to-back single-beat zero-destination packets.
    drive(1'b1, 64'hDD, 4'd8, 1'b1, 1'b0, 4'b0000, 4'b1111);
    for (int n = 0; n < 65534; n++) @(posedge i_clk);
    #1;
    checkOutput("drops near max", {48'b0, o_drops}, 64'hFFFE);
    @(posedge i_clk);
    #1;
    checkOutput("drops at max", {48'b0, o_drops}, 64'hFFFF);
    @(posedge i_clk);
    #1;
    checkOutput("drops saturated", {48'b0, o_drops}, 64'hFFFF);
    checkOutput("drops M_VALID", {60'b0, M_VALID}, 64'h0);
    drive(1'b0, 64'h0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b1111);
    @(posedge i_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
